// File: rtl/riscv_package.sv
// Shared core types; this block only needs the ALU operation encoding.
package riscv_package;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_ADD = 2'd2,
    ALU_SUB = 2'd3
  } alu_operation_e;

endpackage

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two valid/ready requesters.
// Operands are registered toward the ALU and the result is registered on the way back.
module alu_share_arbiter
  import riscv_package::*;
#(
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [DW-1:0]  req_operand_a [2],
  input  logic [DW-1:0]  req_operand_b [2],
  input  alu_operation_e req_operation [2],
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [DW-1:0]  rsp_result,
  output logic [DW-1:0]  alu_operand_a,
  output logic [DW-1:0]  alu_operand_b,
  output alu_operation_e alu_operation,
  input  logic [DW-1:0]  alu_result
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e state;
  logic   last_grant;
  logic   owner;
  logic   grant;
  logic   grant_valid;

  // A tie goes to whoever was not granted last; only IDLE can accept.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (state == IDLE) begin
      case (req_valid)
        2'b01: begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant       = ~last_grant;
        end
        default: begin
          grant_valid = 1'b0;
          grant       = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = grant_valid ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_result    <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operation <= ALU_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_operand_a <= req_operand_a[grant];
            alu_operand_b <= req_operand_b[grant];
            alu_operation <= req_operation[grant];
            owner         <= grant;
            last_grant    <= grant;
            state         <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // Only the owner's consume completes the transaction.
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 2'b00;
        end
      endcase
    end
  end

endmodule
